// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    // Controller states; encodings are fixed so waveforms match across blocks.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Widest supported operand; users slice the constants below to N bits.
    localparam int unsigned MAX_N = 64;

    // Quotient reported for a zero divisor (all ones at any width).
    localparam logic [MAX_N-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift A:Q left by one, trial-subtract M,
// keep the difference when it did not borrow and shift the quotient bit into Q.
module div_step #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] q,
    input  logic [N-1:0] m,
    output logic [N-1:0] a_next,
    output logic [N-1:0] q_next
);

    logic [N:0] shifted;
    logic [N:0] trial;

    // Trial subtraction; the borrow bit trial[N] decides restore vs keep.
    always_comb begin
        shifted = {a, q[N-1]};
        trial   = shifted - {1'b0, m};
        if (!trial[N]) begin
            a_next = trial[N-1:0];
        end else begin
            a_next = shifted[N-1:0];
        end
        q_next = {q[N-2:0], ~trial[N]};
    end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised sequential radix-2 restoring divider with busy/done handshake.
// One iteration per clock; divide-by-zero and signed-overflow flags.
// Build option: define DIV_SIGNED_EN to honour signed_mode (two's-complement
// operands, sign correction, overflow flag). Without it every operation is
// unsigned and overflow stays 0; the FIX cycle remains so latency is unchanged.
module div_seq_param
    import div_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam logic [N-1:0]     QUOT_DIV0 = DIV0_QUOT[N-1:0];
    localparam logic [N-1:0]     MIN_NEG   = {1'b1, {(N - 1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     quot_q, quot_d;
    logic [N-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [N-1:0]     step_a, step_q;
    logic [N-1:0]     dvd_abs, dvs_abs;
    logic [N-1:0]     quot_fix, rem_fix;
    logic             ovf_fix;

    // Start is only honoured when no division is in flight.
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef DIV_SIGNED_EN
    logic neg_quot_q;
    logic neg_rem_q;
    logic ovf_pend_q;
    logic dvd_neg, dvs_neg;

    assign dvd_neg = signed_mode & dividend[N-1];
    assign dvs_neg = signed_mode & divisor[N-1];
    assign dvd_abs = dvd_neg ? -dividend : dividend;
    assign dvs_abs = dvs_neg ? -divisor : divisor;

    // Result signs and the -2^(N-1) / -1 case are latched with the operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else if (accept) begin
            neg_quot_q <= dvd_neg ^ dvs_neg;
            neg_rem_q  <= dvd_neg;
            ovf_pend_q <= signed_mode && (dividend == MIN_NEG) && (&divisor);
        end
    end

    // Truncating division: quotient sign is the XOR, remainder follows dividend.
    assign quot_fix = neg_quot_q ? -q_q : q_q;
    assign rem_fix  = neg_rem_q ? -a_q : a_q;
    assign ovf_fix  = ovf_pend_q;
`else
    logic unused_signed_mode;
    logic [N-1:0] unused_min_neg;

    assign unused_signed_mode = signed_mode;
    assign unused_min_neg     = MIN_NEG;
    assign dvd_abs            = dividend;
    assign dvs_abs            = divisor;
    assign quot_fix           = q_q;
    assign rem_fix            = a_q;
    assign ovf_fix            = 1'b0;
`endif

    div_step #(
        .N (N)
    ) u_step (
        .a      (a_q),
        .q      (q_q),
        .m      (m_q),
        .a_next (step_a),
        .q_next (step_q)
    );

    // Next-state logic and datapath updates for the division sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        dvd_d   = dvd_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    a_d     = '0;
                    q_d     = dvd_abs;
                    m_d     = dvs_abs;
                    dvd_d   = dividend;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                cnt_d = '0;
                // A zero divisor skips the iterations but still passes FIX,
                // keeping the divide-by-zero result two cycles after start.
                state_d = (m_q == '0) ? FIX : ITER;
            end
            ITER: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (m_q == '0) begin
                    quot_d = QUOT_DIV0;
                    rem_d  = dvd_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = quot_fix;
                    rem_d  = rem_fix;
                    ovf_d  = ovf_fix;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and result registers; reset aborts any division.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        busy = (state_q == LOAD) || (state_q == ITER) || (state_q == FIX);
        done = (state_q == DONE);
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
